checked_fifo: RTL

CHECKED_FIFO -- requirements
Module: checked_fifo

---
 rtl/checked_fifo_pkg.sv | 36 +++
 rtl/checked_fifo_mem.sv | 38 +++
 rtl/checked_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/checked_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checked_fifo_pkg
// Description : Shared types and helpers for the parity-checked FIFO.
//               - parity_mode_e : selects even or odd parity.
//               - calc_parity   : XOR-reduces the low 'width' bits of a word.
// Revision    : 1.0 - initial release
// ============================================================================
package checked_fifo_pkg;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } parity_mode_e;

    // Widest word calc_parity can fold; callers zero-extend into this width.
    localparam int PAR_MAX_W = 256;

    // XOR of bits [width-1:0]. Zero-extension does not change the result,
    // so any word up to PAR_MAX_W bits can share this one function.
    function automatic logic calc_parity(
        input logic [PAR_MAX_W-1:0] data,
        input int unsigned          width
    );
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
            if (i < width) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage : checked_fifo_pkg
`default_nettype wire

// File: rtl/checked_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : checked_fifo_mem
// Description : DEPTH x WIDTH storage array, one synchronous write port and
//               one asynchronous (combinational) read port. Not reset.
// Ports       : clk        - write clock, rising edge
//               wr_en_i    - write enable
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address
//               rd_data_o  - read data, combinational from the array
// Revision    : 1.0 - initial release
// ============================================================================
module checked_fifo_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : checked_fifo_mem
`default_nettype wire

// File: rtl/checked_fifo.sv
`default_nettype none
// ============================================================================
// Module      : checked_fifo
// Description : First-word fall-through FIFO with per-entry parity checking.
//               Corrupt head entries are either silently discarded (DROP_ERR=1)
//               or delivered with pop_err_o raised (DROP_ERR=0); either way a
//               saturating error counter records them.
// Ports       : clk, rst_n       - clock / asynchronous active-low reset
//               push_data_i      - payload, MSB is producer parity
//               push_valid_i     - producer offers data
//               push_grant_o     - FIFO has room
//               pop_grant_i      - consumer takes head
//               pop_data_o       - head entry
//               pop_valid_o      - head entry deliverable
//               pop_err_o        - head entry corrupt (flag mode only)
//               level_o          - occupancy
//               almost_full_o    - level_o >= AF_THRESH
//               almost_empty_o   - level_o <= AE_THRESH
//               err_cnt_o        - saturating parity error count
//               err_clr_i        - synchronous clear of err_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
module checked_fifo
    import checked_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 1,
    parameter int DROP_ERR   = 1,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int ERR_W      = 8,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH:0]   push_data_i,
    input  logic                  push_valid_i,
    output logic                  push_grant_o,
    input  logic                  pop_grant_i,
    output logic [DATA_WIDTH:0]   pop_data_o,
    output logic                  pop_valid_o,
    output logic                  pop_err_o,
    output logic [LW-1:0]         level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ERR_W-1:0]      err_cnt_o,
    input  logic                  err_clr_i
);

    localparam int           EW      = DATA_WIDTH + 1;
    localparam int           PW      = $clog2(FIFO_DEPTH);
    localparam parity_mode_e MODE    = (EVEN_ODD != 0) ? ODD : EVEN;
    localparam bit           PAR_EN  = (PARITY_BIT != 0);
    localparam bit           DROP    = (DROP_ERR != 0);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [EW-1:0]    head;
    logic             not_empty;
    logic             corrupt;
    logic             push_fire;
    logic             pop_fire;
    logic             discard;
    logic             head_adv;
    logic             err_inc;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    checked_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push_fire),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (push_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head)
    );

    always_comb begin
        not_empty = (level_q != '0);
        corrupt   = PAR_EN &&
                    (calc_parity(PAR_MAX_W'(head), EW) != logic'(MODE));
        push_fire = push_valid_i && (level_q != LW'(FIFO_DEPTH));
        pop_fire  = not_empty && !(corrupt && DROP) && pop_grant_i;
        // A corrupt head in drop mode leaves on its own, no grant needed.
        discard   = not_empty && corrupt && DROP;
        head_adv  = pop_fire || discard;
        // In drop mode pop_fire never carries a corrupt entry, so this covers
        // both discards and flagged pops.
        err_inc   = head_adv && corrupt;

        wr_ptr_d  = push_fire ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = head_adv  ? ptr_next(rd_ptr_q) : rd_ptr_q;

        level_d   = level_q;
        if (push_fire && !head_adv) begin
            level_d = level_q + LW'(1);
        end else if (!push_fire && head_adv) begin
            level_d = level_q - LW'(1);
        end

        err_cnt_d = err_cnt_q;
        if (err_clr_i) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign push_grant_o   = (level_q != LW'(FIFO_DEPTH));
    assign pop_data_o     = head;
    assign pop_valid_o    = not_empty && !(corrupt && DROP);
    assign pop_err_o      = !DROP && corrupt && not_empty;
    assign level_o        = level_q;
    assign almost_full_o  = (32'(level_q) >= AF_THRESH);
    assign almost_empty_o = (32'(level_q) <= AE_THRESH);
    assign err_cnt_o      = err_cnt_q;

endmodule : checked_fifo
`default_nettype wire
